// File: rtl/aes_spi_responder.sv
// SPI responder for one AES frame: shifts in block and key, runs the core, shifts out the result.
// Optional sticky late-result flag when AES_SPI_RESP_ERR_EN is defined.
module aes_spi_responder #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 256,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              SDI,
  input  logic [1:0]        Nk_val,
  output logic              SDO,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  output logic [1:0]        core_Nk_val,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              frame_done
`ifdef AES_SPI_RESP_ERR_EN
  ,
  output logic              late_err
`endif
);

  typedef enum logic [1:0] {
    RX_DATA,
    RX_KEY,
    GAP,
    TX
  } state_t;

  localparam logic [8:0] DATA_LAST = 9'(DATA_W - 1);
  localparam logic [8:0] KEY_LAST  = 9'(KEY_W - 1);
  localparam logic [8:0] GAP_LAST  = 9'(GAP_CYCLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [8:0]        cnt_q;
  logic [8:0]        cnt_d;
  logic [DATA_W-1:0] tx_q;
  logic              rv_q;
  logic              start_q;
  logic              done_q;
  logic              sdo_q;
  logic              last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 9'd1;
    last    = 1'b0;
    unique case (state_q)
      RX_DATA: begin
        last = (cnt_q == DATA_LAST);
        if (last) state_d = RX_KEY;
      end
      RX_KEY: begin
        last = (cnt_q == KEY_LAST);
        if (last) state_d = GAP;
      end
      GAP: begin
        last = (cnt_q == GAP_LAST);
        if (last) state_d = TX;
      end
      TX: begin
        last = (cnt_q == DATA_LAST);
        if (last) state_d = RX_DATA;
      end
      default: state_d = RX_DATA;
    endcase
    if (last) cnt_d = '0;
    if (CS) begin
      state_d = RX_DATA;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_DATA;
      cnt_q       <= '0;
      tx_q        <= '0;
      rv_q        <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      sdo_q       <= 1'b0;
      core_data   <= '0;
      core_key    <= '0;
      core_Nk_val <= 2'b00;
`ifdef AES_SPI_RESP_ERR_EN
      late_err    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (CS) begin
        sdo_q <= 1'b0;
        rv_q  <= 1'b0;
        tx_q  <= '0;
      end else begin
        unique case (state_q)
          RX_DATA: begin
            core_data <= {core_data[DATA_W-2:0], SDI};
            sdo_q     <= 1'b0;
          end
          RX_KEY: begin
            core_key <= {core_key[KEY_W-2:0], SDI};
            if (cnt_q == 9'd0) core_Nk_val <= Nk_val;
            if (last) begin
              start_q <= 1'b1;
              tx_q    <= '0;
              rv_q    <= 1'b0;
            end
          end
          GAP: begin
            if (core_done) begin
              tx_q <= core_result;
              rv_q <= 1'b1;
            end
`ifdef AES_SPI_RESP_ERR_EN
            if (last && !(rv_q || core_done)) late_err <= 1'b1;
`endif
          end
          TX: begin
            sdo_q <= tx_q[DATA_W-1];
            tx_q  <= tx_q << 1;
            if (last) begin
              done_q <= 1'b1;
              rv_q   <= 1'b0;
            end
          end
          default: sdo_q <= 1'b0;
        endcase
      end
    end
  end

  // A chip-select abort landing on the start cycle must not launch the core
  assign core_start = start_q & ~CS;
  assign frame_done = done_q;
  assign SDO        = sdo_q;

endmodule

// File: tb/tb_aes_spi_responder.sv
// Randomized scoreboard bench for aes_spi_responder.
// Optional late_err checks follow AES_SPI_RESP_ERR_EN.
module tb_aes_spi_responder;
  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         CS;
  logic         SDI;
  logic [1:0]   Nk_val;
  logic         SDO;
  logic         core_start;
  logic [127:0] core_data;
  logic [255:0] core_key;
  logic [1:0]   core_Nk_val;
  logic         core_done;
  logic [127:0] core_result;
  logic         frame_done;
`ifdef AES_SPI_RESP_ERR_EN
  logic         late_err;
`endif

  aes_spi_responder #(
    .DATA_W(128),
    .KEY_W(256),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .CS(CS),
    .SDI(SDI),
    .Nk_val(Nk_val),
    .SDO(SDO),
    .core_start(core_start),
    .core_data(core_data),
    .core_key(core_key),
    .core_Nk_val(core_Nk_val),
    .core_done(core_done),
    .core_result(core_result),
    .frame_done(frame_done)
`ifdef AES_SPI_RESP_ERR_EN
    ,
    .late_err(late_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic [255:0] k;
    logic [1:0]   nk;
  } start_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           n_start = 0;
  int           frame_start = 0;
  int           next_lat = 1;
  logic [127:0] next_result = '0;
  logic         exp_late = 1'b0;
  start_t       start_q[$];
  logic [127:0] res_q[$];
  int           done_cycs[$];
  int           start_cycs[$];
  logic [127:0] sdo_hist = '0;
  start_t       mon_e;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks core launches and reassembled SDO words
  always @(negedge clk) begin
    sdo_hist = {sdo_hist[126:0], SDO};
    if (core_start) begin
      n_start++;
      start_cycs.push_back(cyc);
      if (start_q.size() == 0) flag("unexpected_core_start");
      else begin
        mon_e = start_q.pop_front();
        chk("core_data", 256'(core_data), 256'(mon_e.d));
        chk("core_key", core_key, mon_e.k);
        chk("core_Nk_val", 256'(core_Nk_val), 256'(mon_e.nk));
      end
    end
    if (frame_done) begin
      done_cycs.push_back(cyc);
      if (res_q.size() == 0) flag("unexpected_frame_done");
      else chk("sdo_result", 256'(sdo_hist), 256'(res_q.pop_front()));
    end
  end

  // Core model: answers next_result after next_lat cycles
  initial begin
    int l;
    logic [127:0] r;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        l = next_lat;
        r = next_result;
        repeat (l) @(negedge clk);
        core_done = 1'b1;
        core_result = r;
        @(negedge clk);
        core_done = 1'b0;
        core_result = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic idle(input int n);
    CS = 1'b1;
    SDI = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [127:0] d, input logic [255:0] k,
                            input logic [1:0] nk, input logic [1:0] nk2,
                            input logic [127:0] r, input int lat,
                            input int abort_bit, input int rst_bit);
    start_t e;
    next_result = r;
    next_lat = lat;
    frame_start = cyc;
    if (abort_bit < 0) begin
      e.d = d;
      e.k = k;
      e.nk = nk;
      start_q.push_back(e);
      // result usable only if it lands inside the idle gap
      if (rst_bit < 0) res_q.push_back(lat < GAP ? r : 128'd0);
      if (lat >= GAP) exp_late = 1'b1;
    end
    CS = 1'b0;
    Nk_val = ~nk;
    for (int i = 0; i < 128; i++) begin
      SDI = d[127-i];
      @(negedge clk);
    end
    for (int i = 0; i < 256; i++) begin
      if (i == abort_bit) begin
        CS = 1'b1;
        @(negedge clk);
        CS = 1'b0;
        return;
      end
      Nk_val = (i < 128) ? nk : nk2;
      SDI = k[255-i];
      @(negedge clk);
    end
    for (int i = 0; i < GAP + 128; i++) begin
      SDI = 1'($urandom);
      if (rst_bit >= 0 && i == GAP + rst_bit) begin
        @(posedge clk);
        #2;
        chk("sdo_before_rst", 256'(SDO), 256'(1));
        rst = 1'b1;
        #1;
        chk("rst_sdo", 256'(SDO), 256'(0));
        chk("rst_frame_done", 256'(frame_done), 256'(0));
        chk("rst_core_start", 256'(core_start), 256'(0));
        chk("rst_core_data", 256'(core_data), 256'(0));
        exp_late = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [127:0] d;
    logic [255:0] k;
    rst = 1'b1;
    CS = 1'b1;
    SDI = 1'b0;
    Nk_val = 2'b00;
    #12;
    chk("reset_sdo", 256'(SDO), 256'(0));
    chk("reset_core_start", 256'(core_start), 256'(0));
    chk("reset_frame_done", 256'(frame_done), 256'(0));
    chk("reset_core_data", 256'(core_data), 256'(0));
    chk("reset_core_key", core_key, 256'(0));
    chk("reset_core_nk", 256'(core_Nk_val), 256'(0));
`ifdef AES_SPI_RESP_ERR_EN
    chk("reset_late_err", 256'(late_err), 256'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // encrypt vector, Nk4
    send_frame(128'h00112233445566778899aabbccddeeff,
               {128'h000102030405060708090a0b0c0d0e0f, 128'd0},
               2'b00, 2'b00,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, -1, -1);
    idle(2);
    chk("start_offset", 256'(start_cycs[$] - frame_start), 256'(384));
    chk("frame_len", 256'(done_cycs[$] - frame_start), 256'(516));

    // Nk latched on first key bit only
    n0 = n_start;
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b10, 2'b00,
               rnd128(), 1, -1, -1);
    idle(2);
    chk("nk_start_count", 256'(n_start - n0), 256'(1));
    chk("nk_start_offset", 256'(start_cycs[$] - frame_start), 256'(384));
    chk("nk_latched", 256'(core_Nk_val), 256'(2));
`ifdef AES_SPI_RESP_ERR_EN
    chk("late_err_clear", 256'(late_err), 256'(0));
`endif

    // late result
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b01, 2'b01,
               rnd128(), 6, -1, -1);
    idle(2);
`ifdef AES_SPI_RESP_ERR_EN
    chk("late_err_set", 256'(late_err), 256'(1));
`endif

    // abort at key edge 100, then a full frame
    n0 = n_start;
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b00, 2'b00,
               rnd128(), 1, 99, -1);
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b01, 2'b01,
               rnd128(), 2, -1, -1);
    idle(2);
    chk("abort_start_count", 256'(n_start - n0), 256'(1));

    // async reset during TX bit 50
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b10, 2'b10,
               {128{1'b1}}, 1, -1, 50);
    idle(2);
`ifdef AES_SPI_RESP_ERR_EN
    chk("rst_late_err", 256'(late_err), 256'(0));
`endif
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b00, 2'b00,
               rnd128(), 3, -1, -1);
    idle(2);

    // back-to-back frames, CS low throughout
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b01, 2'b10,
               rnd128(), 1, -1, -1);
    send_frame(rnd128(), {rnd128(), rnd128()}, 2'b11, 2'b00,
               rnd128(), 2, -1, -1);
    idle(2);
    chk("b2b_spacing", 256'(done_cycs[$] - done_cycs[$-1]), 256'(516));

    // randomized frames
    for (int t = 0; t < 10; t++) begin
      d = rnd128();
      k = {rnd128(), rnd128()};
      send_frame(d, k, 2'($urandom), 2'($urandom), rnd128(),
                 int'($urandom_range(1, 6)), -1, -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    chk("start_q_empty", 256'(start_q.size()), 256'(0));
    chk("res_q_empty", 256'(res_q.size()), 256'(0));
`ifdef AES_SPI_RESP_ERR_EN
    chk("late_err_final", 256'(late_err), 256'(exp_late));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
